// File: rtl/fir_decimator.sv
// fir_decimator: decimates the fir_filter output stream by DECIM into a small FWFT FIFO with a sticky overflow flag.
// Define DECIM_AVG_EN to push the boxcar average of each group; the default build pushes the last sample of the group.
module fir_decimator #(
    parameter int DATA_W     = 16,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic signed [DATA_W-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_W-1:0]      out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int SHIFT = $clog2(DECIM);
    localparam int PH_W  = (DECIM > 1) ? SHIFT : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(DECIM - 1);
    localparam logic [LW-1:0]   LVL_FULL = LW'(FIFO_DEPTH);

    logic [PH_W-1:0]          phase_r;
    logic                     last_phase_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     full_s;
    logic                     wr_en_s;
    logic                     drop_s;
    logic signed [DATA_W-1:0] push_data_s;
    logic signed [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            rd_ptr_r;
    logic [LW-1:0]            level_r;
    logic                     overflow_r;

    // Group boundary and FIFO control decode
    always_comb begin
        last_phase_s = (phase_r == PH_LAST);
        push_s       = in_valid && last_phase_s;
        pop_s        = (level_r != {LW{1'b0}}) && out_ready;
        full_s       = (level_r == LVL_FULL);
        // A pop on the same edge frees the slot, so a full FIFO still accepts the push
        wr_en_s      = push_s && (!full_s || pop_s);
        drop_s       = push_s && full_s && !pop_s;
    end

    // Phase counter: advances on accepted samples only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r <= {PH_W{1'b0}};
        end else if (in_valid) begin
            if (last_phase_s) begin
                phase_r <= {PH_W{1'b0}};
            end else begin
                phase_r <= phase_r + {{(PH_W-1){1'b0}}, 1'b1};
            end
        end else begin
            phase_r <= phase_r;
        end
    end

`ifdef DECIM_AVG_EN
    localparam int ACC_W = DATA_W + SHIFT;

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] in_ext_s;
    logic signed [ACC_W-1:0] sum_s;

    // Group sum including the current sample; arithmetic shift floors toward minus infinity
    always_comb begin
        in_ext_s    = ACC_W'(in_data);
        sum_s       = acc_r + in_ext_s;
        push_data_s = DATA_W'(sum_s >>> SHIFT);
    end

    // Accumulator restarts at zero once a group closes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (in_valid) begin
            if (last_phase_s) begin
                acc_r <= {ACC_W{1'b0}};
            end else begin
                acc_r <= sum_s;
            end
        end else begin
            acc_r <= acc_r;
        end
    end
`else
    // Pick mode: the closing sample of the group is pushed as-is
    always_comb begin
        push_data_s = in_data;
    end
`endif

    // FIFO storage; cleared on reset so out_data reads zero afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy tracking; simultaneous write and pop leave it unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_r <= {LW{1'b0}};
        end else begin
            case ({wr_en_s, pop_s})
                2'b10:   level_r <= level_r + {{(LW-1){1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{(LW-1){1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky drop indicator, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Output view of the FIFO head and status registers
    always_comb begin
        out_valid  = (level_r != {LW{1'b0}});
        out_data   = mem_r[rd_ptr_r];
        fifo_level = level_r;
        overflow   = overflow_r;
    end

endmodule

// File: tb/tb_fir_decimator.sv
// Scoreboard bench for fir_decimator (DECIM=4, FIFO_DEPTH=4); expectations follow DECIM_AVG_EN when defined.
module tb_fir_decimator;
`ifdef DECIM_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [2:0]         fifo_level;
    logic               overflow;

    int tests = 0;
    int fails = 0;
    logic signed [15:0] exp_q[$];

    fir_decimator #(.DATA_W(16), .DECIM(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Hand-derived group results: group g holds samples 4g-3..4g, sum 16g-6, floor(sum/4) = 4g-2
    function automatic logic signed [15:0] grp(input int g);
        return AVG ? 16'(4 * g - 2) : 16'(4 * g);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the sampling edge
    task automatic cyc(input logic v, input int d, input logic r);
        in_valid  = v;
        in_data   = 16'(d);
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && fifo_level != 3'd0; i++) begin
            cyc(1'b0, 0, 1'b1);
        end
    endtask

    // Monitor: every accepted output is compared against the oldest expected value
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: got %0d expected none", out_data);
            end else begin
                logic signed [15:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL out_data: got %0d expected %0d", out_data, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'sd0; out_ready = 1'b0;
        cyc(1'b0, 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Streaming 1..8 with a ready consumer
        exp_q.push_back(grp(1));
        exp_q.push_back(grp(2));
        for (int d = 1; d <= 8; d++) begin
            cyc(1'b1, d, 1'b1);
            if (d == 4 || d == 8) begin
                check("lat_valid", 32'(out_valid), 32'd1);
                check("lat_data", 32'(out_data), 32'(grp(d / 4)));
            end
            if (d == 5) check("pulse_1cyc", 32'(out_valid), 32'd0);
        end
        cyc(1'b0, 0, 1'b1);
        check("t1_overflow", 32'(overflow), 32'd0);
        check("t1_level", 32'(fifo_level), 32'd0);

        // Negative samples -1..-4
        exp_q.push_back(AVG ? -16'sd3 : -16'sd4);
        for (int d = 1; d <= 4; d++) cyc(1'b1, -d, 1'b1);
        check("neg_valid", 32'(out_valid), 32'd1);
        check("neg_data", 32'(out_data), 32'(AVG ? -16'sd3 : -16'sd4));
        cyc(1'b0, 0, 1'b1);
        check("neg_q_empty", 32'(exp_q.size()), 32'd0);

        // Stalled consumer: fill, drop sample group 5, then drain
        do_reset();
        for (int g = 1; g <= 4; g++) exp_q.push_back(grp(g));
        for (int d = 1; d <= 20; d++) begin
            cyc(1'b1, d, 1'b0);
            if (d == 16) begin
                check("fill_level", 32'(fifo_level), 32'd4);
                check("fill_no_ovf", 32'(overflow), 32'd0);
            end
        end
        check("drop_level", 32'(fifo_level), 32'd4);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_head", 32'(out_data), 32'(grp(1)));
        drain();
        check("drain_level", 32'(fifo_level), 32'd0);
        check("drain_ovf_sticky", 32'(overflow), 32'd1);
        check("drain_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-group discards partial group and clears overflow
        cyc(1'b1, 1, 1'b1);
        cyc(1'b1, 2, 1'b1);
        do_reset();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        exp_q.push_back(grp(2));
        for (int d = 5; d <= 8; d++) cyc(1'b1, d, 1'b1);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data", 32'(out_data), 32'(grp(2)));
        cyc(1'b0, 0, 1'b1);
        check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

        // Full FIFO with pop on the same edge as the push
        do_reset();
        for (int g = 1; g <= 5; g++) exp_q.push_back(grp(g));
        for (int d = 1; d <= 19; d++) cyc(1'b1, d, 1'b0);
        check("full_level", 32'(fifo_level), 32'd4);
        cyc(1'b1, 20, 1'b1);
        check("pp_level", 32'(fifo_level), 32'd4);
        check("pp_overflow", 32'(overflow), 32'd0);
        check("pp_head", 32'(out_data), 32'(grp(2)));
        drain();
        check("pp_drain_level", 32'(fifo_level), 32'd0);
        check("pp_q_empty", 32'(exp_q.size()), 32'd0);
        check("pp_ovf_final", 32'(overflow), 32'd0);

        // in_valid toggling: phase holds on invalid cycles
        do_reset();
        exp_q.push_back(grp(1));
        cyc(1'b1, 1, 1'b1);
        cyc(1'b0, 99, 1'b1);
        cyc(1'b1, 2, 1'b1);
        cyc(1'b0, 99, 1'b1);
        cyc(1'b1, 3, 1'b1);
        cyc(1'b0, 99, 1'b1);
        check("gap_no_push", 32'(out_valid), 32'd0);
        cyc(1'b1, 4, 1'b1);
        check("gap_valid", 32'(out_valid), 32'd1);
        check("gap_data", 32'(out_data), 32'(grp(1)));
        cyc(1'b0, 0, 1'b1);
        check("gap_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Stage directly downstream of fir_filter. Takes its signed 16-bit output stream and decimates it by DECIM.
- Decimated samples are buffered in a small first-word-fall-through FIFO.
- Samples leave through a valid/ready handshake toward the rate-reduced back end.
- Raises a sticky overflow flag when the consumer stalls long enough to fill the FIFO.

Parameters:
- DATA_W, 16, sample width; matches fir_filter y_out.
- DECIM, 4, decimation factor; power of two, at least 1.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data is valid this cycle; tie high when fed by fir_filter, which emits one sample per clock.
- in_data  input  DATA_W  signed sample from fir_filter y_out.
- out_valid  output  1  FIFO non-empty; out_data holds the oldest sample.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  DATA_W  signed decimated sample.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: a decimated sample was dropped.

Behaviour:
- Reset: rst_n sampled low on a rising edge clears all state.
  - Cleared: phase counter, accumulator, FIFO read/write pointers, FIFO storage, fifo_level, overflow.
  - Outputs after reset: out_valid=0, out_data=0, fifo_level=0, overflow=0.
  - Reset mid-group discards the partial group. The next accepted sample after reset is phase 0.
- Phase counter, range 0..DECIM-1:
  - Advances only on cycles with in_valid=1, wrapping from DECIM-1 to 0.
  - Holds when in_valid=0.
  - The sample accepted at phase DECIM-1 closes a group and generates a push.
  - DECIM=1: every valid sample pushes.
- Pick mode (default build): the pushed value is the in_data accepted at phase DECIM-1, i.e. the last sample of each group.
- Latency: the closing sample is accepted on edge k. It is written to the FIFO on that edge. When the FIFO was empty, out_valid=1 and out_data equal that value in the cycle after edge k.
- FIFO:
  - First-word-fall-through: out_data = storage[rd_ptr]. out_valid = (fifo_level != 0).
  - Pop occurs on a rising edge with out_valid && out_ready.
  - out_data is don't-care while out_valid=0, except after reset, when it is 0.
  - out_ready while empty: no effect.
- Simultaneous events:
  - Push and pop, FIFO not full: both occur; fifo_level unchanged.
  - Push and pop, FIFO full: both occur; no drop; fifo_level stays FIFO_DEPTH.
  - Push, FIFO full, no pop: the new sample is discarded, stored contents untouched, overflow set to 1. overflow stays 1 until reset.
  - Push while empty: out_valid rises next cycle. A same-cycle pop is impossible because out_valid=0.
- Pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- A stalled consumer (out_ready=0) never stalls the input side. There is no backpressure to fir_filter.

Optional Feature:
- Macro: DECIM_AVG_EN.
- Defined (boxcar averaging):
  - A signed accumulator of DATA_W+$clog2(DECIM) bits sums every accepted sample in the group.
  - At phase DECIM-1 the pushed value is (acc + in_data) >>> $clog2(DECIM): arithmetic shift, rounding toward minus infinity, result truncated to DATA_W bits.
  - The accumulator clears to 0 on the same edge; the next group starts fresh.
  - Accumulator resets to 0.
  - DECIM=1 behaves identically to pick mode.
- Undefined: no accumulator is built; pick mode as above.
- Latency, FIFO and overflow rules are identical in both builds.

Test Plan:
- Reset, then in_valid=1 with in_data=1,2,3,...,8 on consecutive cycles, out_ready=1 -> out_data=4 valid one cycle after sample 4, out_data=8 one cycle after sample 8. Each out_valid pulse is 1 cycle. overflow=0.
- DECIM_AVG_EN build, same stimulus -> out_data=2 (10>>>2), then 6 (26>>>2). Inputs -1,-2,-3,-4 (0xFFFF, 0xFFFE, 0xFFFD, 0xFFFC) -> out_data=-3 (0xFFFD), since -10>>>2 = -3.
- out_ready=0, inputs 1..20 -> fifo_level reaches 4 holding 4,8,12,16. Sample 20 is dropped and overflow=1. Then out_ready=1 -> drains 4,8,12,16, fifo_level returns to 0, overflow stays 1.
- FIFO full (4,8,12,16), out_ready=1 in the cycle sample 20 closes its group -> 4 popped, 20 pushed, fifo_level stays 4, overflow=0. Subsequent order is 8,12,16,20.
- in_valid toggling 1,0,1,0 over inputs 1..4 -> phase holds on invalid cycles and the push occurs only after the 4th valid sample; out_data=4.
- Assert rst_n=0 for 1 cycle after inputs 1,2 -> out_valid=0, fifo_level=0, overflow=0. Then inputs 5..8 -> out_data=8; with DECIM_AVG_EN, out_data=6.
